// File: rtl/counter_modulo_down.sv
// Loadable modulo down-counter / timer.
// An accepted start loads mod-1 and enters RUN. Each enabled cycle counts down
// to zero, then the counter either reloads (periodic) or stops (one-shot).
// IMPLEMENTATION selects how the wrap is detected:
//   0 = compare the current count against zero
//   1 = use the borrow out of cnt-1
// Both choices produce cycle-identical outputs.
// Optional macro COUNTER_MODULO_DOWN_STICKY_EN adds the clr input and the
// sticky wrap flag wrs.
module counter_modulo_down #(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH:0]   mod,
`ifdef COUNTER_MODULO_DOWN_STICKY_EN
  input  logic             clr,
  output logic             wrs,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             wrp,
  output logic             bsy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   lod_q, lod_d;
  logic             mds_q, mds_d;
  logic             at_zero;
  logic [WIDTH-1:0] cnt_dec;
  logic             start_ok;

  if (IMPLEMENTATION == 0) begin : g_cmp_cur
    assign at_zero = (cnt_q == '0);
    assign cnt_dec = cnt_q - WIDTH'(1);
  end else if (IMPLEMENTATION == 1) begin : g_cmp_nxt
    logic [WIDTH:0] nxt;
    assign nxt     = {1'b0, cnt_q} - (WIDTH+1)'(1);
    assign at_zero = nxt[WIDTH];
    assign cnt_dec = nxt[WIDTH-1:0];
  end else begin : g_bad_impl
    $fatal(1, "counter_modulo_down: IMPLEMENTATION must be 0 or 1");
  end

  // A start with mod == 0 is ignored; stop overrides a simultaneous start.
  assign start_ok = start && !stop && (mod != '0);

  assign cnt = cnt_q;
  assign bsy = (state_q == RUN);
  assign wrp = (state_q == RUN) && at_zero;

  // State, count and captured configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lod_q   <= '0;
      mds_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lod_q   <= lod_d;
      mds_q   <= mds_d;
    end
  end

  // Next-state logic: stop > start > count/reload/finish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lod_d   = lod_q;
    mds_d   = mds_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start_ok) begin
      state_d = RUN;
      cnt_d   = WIDTH'(mod - (WIDTH+1)'(1));
      lod_d   = mod;
      mds_d   = mode;
    end else if ((state_q == RUN) && ena) begin
      if (!at_zero) begin
        cnt_d = cnt_dec;
      end else if (!mds_q) begin
        cnt_d = WIDTH'(lod_q - (WIDTH+1)'(1));
      end else begin
        state_d = IDLE;
      end
    end
  end

`ifdef COUNTER_MODULO_DOWN_STICKY_EN
  logic wrs_q, wrs_d;

  assign wrs = wrs_q;

  // Sticky wrap flag: a taken wrap sets it and wins over a same-cycle clear.
  always_comb begin
    wrs_d = wrs_q;
    if (wrp && ena) begin
      wrs_d = 1'b1;
    end else if (clr) begin
      wrs_d = 1'b0;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrs_q <= 1'b0;
    end else begin
      wrs_q <= wrs_d;
    end
  end
`endif

endmodule
